seq_alu: RTL and testbench
==========================

Name: seq_alu

Overview:
- Registered, parametrised successor to the single-cycle datapath ALU in the multi-cycle core.
- Keeps the legacy ALU op set and adds iterative unsigned multiply and divide.
- Uses a start/busy/done handshake so the control FSM can stall on long operations.
- Sits between the A/B operand registers and the ALUOut register; result_hi feeds the HI register.

Parameters:
- WIDTH, 32, operand/result width in bits (>=8).
- CNT_W, $clog2(WIDTH+1), iteration-counter width (derived; not overridden).

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  request; sampled only when busy=0
- aluop  in  4  operation code, captured with start
- a  in  WIDTH  operand A, captured with start
- b  in  WIDTH  operand B, captured with start
- busy  out  1  operation in progress; start ignored
- done  out  1  one-cycle pulse when result/zero/result_hi are valid
- result  out  WIDTH  main result (MUL low half, DIV quotient)
- result_hi  out  WIDTH  MUL high half, DIV remainder, 0 otherwise
- zero  out  1  branch/zero flag
- illegal_op  out  1  set with done for an unrecognised aluop

Behaviour:
- Async reset, immediate: state=IDLE, busy=0, done=0, result=0, result_hi=0, zero=0, illegal_op=0, counter=0.
- Opcodes:
  - 0010 ADD; 0110 SUB; 0000 AND; 0001 OR.
  - 0111 SLT: unsigned a<b gives 1, else 0.
  - 0100 EQ: zero=(a==b), result=0.
  - 0011 NE: zero=(a!=b), result=0.
  - 1000 MULU; 1001 DIVU. All others are illegal.
- zero for ADD/SUB/AND/OR/SLT/MULU/DIVU = (result==0).
- ADD/SUB wrap modulo 2^WIDTH; no overflow flag.
- FSM states: IDLE, MUL, DIV, FIN.
- IDLE:
  - start=1 latches a, b, aluop.
  - Single-cycle op or illegal op: go to FIN; result is written on the same edge.
  - MULU: go to MUL, busy=1, counter=0.
  - DIVU with b!=0: go to DIV. DIVU with b==0: go to FIN.
- MUL: shift-add, one multiplier bit per cycle, exactly WIDTH cycles, then FIN with the 2*WIDTH product split into result_hi:result.
- DIV: restoring division, one quotient bit per cycle, exactly WIDTH cycles, then FIN.
- Divide by zero: result = all ones, result_hi = a, zero=0, latency as for a single-cycle op.
- FIN: done=1 for one cycle, busy=0, next state IDLE.
- Latency from the start edge to done high:
  - 1 cycle for single-cycle, illegal and div-by-zero ops.
  - WIDTH+1 cycles for MULU/DIVU.
- busy is high in MUL/DIV only.
- A start in the FIN cycle is accepted (back-to-back issue, 1 op/cycle throughput for single-cycle ops).
- Outputs hold their values after done until the next accepted operation completes. Intermediate values are never visible on result or result_hi.
- A start while busy=1 is dropped: no queuing, operands not re-latched.
- An illegal op gives result=0, result_hi=0, zero=0, illegal_op=1 for the done cycle only.
- Reset mid-iteration aborts the operation; no done is produced.

Optional Feature:
- Macro SEQ_ALU_DIV_EN.
- Defined: DIV state and divider datapath are present; DIVU behaves as above.
- Undefined: no divider logic. DIVU (1001) is treated as an illegal op (1-cycle, illegal_op=1). MULU is unaffected.

Decomposition:
- Shared package seq_alu_pkg holds:
  - opcode localparams: OP_AND, OP_OR, OP_ADD, OP_NE, OP_EQ, OP_SUB, OP_SLT, OP_MULU, OP_DIVU.
  - FSM state encodings S_IDLE, S_MUL, S_DIV, S_FIN.
- The control unit decoder uses the same package.
- One sub-module, seq_alu_muldiv: iterative shift-add/restoring engine with load, step and mode inputs. It exposes the 2*WIDTH accumulator and holds the counter.
- seq_alu keeps the FSM, the single-cycle ops and the output registers.

Test Plan (WIDTH=32):
- ADD a=5, b=7, then SUB a=3, b=5 in consecutive cycles: done on each following cycle; result=12, then 0xFFFFFFFE; zero=0 both times.
- EQ a=b=0x1234, then NE with the same operands: zero=1, then zero=0; result=0 both times.
- MULU a=0xFFFFFFFF, b=2: busy high for 32 cycles; done at cycle 33; result=0xFFFFFFFE, result_hi=1.
- DIVU a=100, b=7: done at cycle 33 with result=14, result_hi=2.
- DIVU a=9, b=0: done at cycle 1 with result=0xFFFFFFFF, result_hi=9.
- Without SEQ_ALU_DIV_EN, the same DIVU gives illegal_op=1 and result=0.
- MULU started, start+ADD pulsed at cycle 5 (ignored), reset asserted at cycle 10: all outputs 0 immediately; no done follows.
- A new ADD 1+1 after reset gives result=2 at latency 1.

Source files
------------

// File: rtl/seq_alu_pkg.sv
// seq_alu_pkg: shared definitions for the sequential ALU and the control-unit
// decoder. Holds the ALU opcode encodings and the ALU FSM state encodings.
// Ports: none (package).
package seq_alu_pkg;

  // ALU operation codes (legacy single-cycle set plus iterative MULU/DIVU)
  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_NE   = 4'b0011;
  localparam logic [3:0] OP_EQ   = 4'b0100;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_MULU = 4'b1000;
  localparam logic [3:0] OP_DIVU = 4'b1001;

  // ALU sequencing states
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_FIN  = 2'd3
  } state_t;

endpackage

// File: rtl/seq_alu_muldiv.sv
// seq_alu_muldiv: iterative unsigned shift-add multiplier and (optionally)
// restoring divider, one bit per step.
// Optional feature macro: SEQ_ALU_DIV_EN (restoring divide datapath).
// Ports:
//   clk, reset   clock and asynchronous active-high reset
//   load         initialise accumulator to {0, a} and latch b, clear counter
//   step         perform one iteration (multiply when mode=0, divide when mode=1)
//   mode         0 = multiply, 1 = divide
//   a, b         operands (sampled on load)
//   acc          accumulator value as it will be after this cycle's load/step
//                (MUL: {hi, lo} product; DIV: {remainder, quotient})
//   count        number of steps taken since the last load
module seq_alu_muldiv
  import seq_alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic               step,
  input  logic               mode,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] acc,
  output logic [CNT_W-1:0]   count
);

  logic [2*WIDTH-1:0] acc_q;
  logic [WIDTH-1:0]   b_q;
  logic [WIDTH:0]     mul_sum;
`ifdef SEQ_ALU_DIV_EN
  logic [WIDTH:0]     div_part;
  logic [WIDTH:0]     div_diff;
`endif

  // Next accumulator value: load, one multiply step or one divide step
  always_comb begin
    // Upper half plus multiplicand when the current multiplier LSB is set;
    // the extra bit keeps the carry that is shifted back in.
    mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} +
              (acc_q[0] ? {1'b0, b_q} : {(WIDTH+1){1'b0}});
`ifdef SEQ_ALU_DIV_EN
    // Partial remainder shifted left with the next dividend bit pulled in
    div_part = acc_q[2*WIDTH-1:WIDTH-1];
    div_diff = div_part - {1'b0, b_q};
`endif
    acc = acc_q;
    if (load) begin
      acc = {{WIDTH{1'b0}}, a};
    end else if (step && !mode) begin
      acc = {mul_sum, acc_q[WIDTH-1:1]};
`ifdef SEQ_ALU_DIV_EN
    end else if (step && mode) begin
      // MSB of the difference set means borrow: restore, quotient bit 0
      if (!div_diff[WIDTH]) begin
        acc = {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
      end else begin
        acc = {div_part[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
      end
`endif
    end else begin
      acc = acc_q;
    end
  end

  // Accumulator, latched divisor/multiplicand and step counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_q <= {(2*WIDTH){1'b0}};
      b_q   <= {WIDTH{1'b0}};
      count <= {CNT_W{1'b0}};
    end else begin
      acc_q <= acc;
      if (load) begin
        b_q   <= b;
        count <= {CNT_W{1'b0}};
      end else if (step) begin
        count <= count + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

endmodule

// File: rtl/seq_alu.sv
// seq_alu: registered ALU with start/busy/done handshake. Single-cycle ops
// (ADD, SUB, AND, OR, SLT, EQ, NE) complete on the start edge; MULU (and DIVU
// when enabled) iterate for WIDTH cycles in seq_alu_muldiv.
// Optional feature macro: SEQ_ALU_DIV_EN. Undefined: DIVU is an illegal op.
// Ports:
//   clk, reset   clock and asynchronous active-high reset
//   start        request, sampled only when busy=0
//   aluop, a, b  operation and operands, captured with start
//   busy         high while iterating (MUL/DIV states)
//   done         one-cycle pulse when result/result_hi/zero are valid
//   result       main result (MUL low half, DIV quotient)
//   result_hi    MUL high half, DIV remainder, 0 otherwise
//   zero         zero/branch flag
//   illegal_op   high with done for an unrecognised opcode
module seq_alu
  import seq_alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH + 1)  // derived; not to be overridden
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       aluop,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             zero,
  output logic             illegal_op
);

  state_t state, state_nxt;
  logic load, step, mode, cap_alu, cap_md, illegal_q;
  logic [WIDTH-1:0]   alu_res, alu_hi;
  logic               alu_zero, alu_ill;
  logic [2*WIDTH-1:0] md_acc;
  logic [CNT_W-1:0]   md_count;
  logic               md_last;

  seq_alu_muldiv #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_muldiv (
    .clk   (clk),
    .reset (reset),
    .load  (load),
    .step  (step),
    .mode  (mode),
    .a     (a),
    .b     (b),
    .acc   (md_acc),
    .count (md_count)
  );

  // The step taken while count==WIDTH-1 is the last of WIDTH iterations
  assign md_last = (md_count == CNT_W'(WIDTH - 1));

  // Single-cycle result, computed straight from the incoming operands
  always_comb begin
    alu_res  = {WIDTH{1'b0}};
    alu_hi   = {WIDTH{1'b0}};
    alu_ill  = 1'b0;
    alu_zero = 1'b0;
    case (aluop)
      OP_ADD:  alu_res = a + b;
      OP_SUB:  alu_res = a - b;
      OP_AND:  alu_res = a & b;
      OP_OR:   alu_res = a | b;
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, (a < b)};
      OP_EQ:   alu_res = {WIDTH{1'b0}};
      OP_NE:   alu_res = {WIDTH{1'b0}};
      OP_MULU: alu_res = {WIDTH{1'b0}};  // iterative; never captured from here
`ifdef SEQ_ALU_DIV_EN
      OP_DIVU: begin
        // Only captured for b==0: quotient saturates, remainder is a
        alu_res = {WIDTH{1'b1}};
        alu_hi  = a;
      end
`endif
      default: alu_ill = 1'b1;
    endcase
    if (aluop == OP_EQ) begin
      alu_zero = (a == b);
    end else if (aluop == OP_NE) begin
      alu_zero = (a != b);
    end else if (alu_ill) begin
      alu_zero = 1'b0;
    end else begin
      alu_zero = (alu_res == {WIDTH{1'b0}});
    end
  end

  // Next-state and datapath control
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    step      = 1'b0;
    mode      = 1'b0;
    cap_alu   = 1'b0;
    cap_md    = 1'b0;
    case (state)
      S_IDLE, S_FIN: begin
        if (start) begin
          if (aluop == OP_MULU) begin
            state_nxt = S_MUL;
            load      = 1'b1;
`ifdef SEQ_ALU_DIV_EN
          end else if ((aluop == OP_DIVU) && (b != {WIDTH{1'b0}})) begin
            state_nxt = S_DIV;
            load      = 1'b1;
            mode      = 1'b1;
`endif
          end else begin
            state_nxt = S_FIN;
            cap_alu   = 1'b1;
          end
        end else begin
          state_nxt = S_IDLE;
        end
      end
      S_MUL: begin
        step = 1'b1;
        if (md_last) begin
          state_nxt = S_FIN;
          cap_md    = 1'b1;
        end else begin
          state_nxt = S_MUL;
        end
      end
`ifdef SEQ_ALU_DIV_EN
      S_DIV: begin
        step = 1'b1;
        mode = 1'b1;
        if (md_last) begin
          state_nxt = S_FIN;
          cap_md    = 1'b1;
        end else begin
          state_nxt = S_DIV;
        end
      end
`endif
      default: state_nxt = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Output registers: updated only when an operation completes
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      result    <= {WIDTH{1'b0}};
      result_hi <= {WIDTH{1'b0}};
      zero      <= 1'b0;
      illegal_q <= 1'b0;
    end else if (cap_alu) begin
      result    <= alu_res;
      result_hi <= alu_hi;
      zero      <= alu_zero;
      illegal_q <= alu_ill;
    end else if (cap_md) begin
      result    <= md_acc[WIDTH-1:0];
      result_hi <= md_acc[2*WIDTH-1:WIDTH];
      zero      <= (md_acc[WIDTH-1:0] == {WIDTH{1'b0}});
      illegal_q <= 1'b0;
    end
  end

  assign done       = (state == S_FIN);
  assign busy       = (state == S_MUL) || (state == S_DIV);
  // illegal flag is only reported alongside done
  assign illegal_op = illegal_q && (state == S_FIN);

endmodule

// File: tb/tb_seq_alu.sv
// tb_seq_alu: self-checking bench for seq_alu (WIDTH=32). Directed vector
// table, hand-written multi-cycle sequences (dropped start, reset abort) and
// randomized operations checked against a behavioural model.
module tb_seq_alu;

  localparam int W = 32;
  localparam logic [3:0] C_AND = 4'b0000, C_OR = 4'b0001, C_ADD = 4'b0010,
                         C_NE = 4'b0011, C_EQ = 4'b0100, C_SUB = 4'b0110,
                         C_SLT = 4'b0111, C_MULU = 4'b1000, C_DIVU = 4'b1001;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic start = 1'b0;
  logic [3:0] aluop = 4'b0000;
  logic [W-1:0] a = '0, b = '0;
  logic busy, done, zero, illegal_op;
  logic [W-1:0] result, result_hi;

  int total = 0;
  int bad = 0;

  seq_alu #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .aluop(aluop), .a(a), .b(b),
    .busy(busy), .done(done), .result(result), .result_hi(result_hi),
    .zero(zero), .illegal_op(illegal_op)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] res;
    logic [W-1:0] hi;
    logic         z;
    logic         ill;
    int           lat;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference behaviour derived from the opcode definitions
  function automatic void model(input logic [3:0] op, input logic [W-1:0] x, input logic [W-1:0] y,
                                output logic [W-1:0] r, output logic [W-1:0] h,
                                output logic z, output logic il, output int lat);
    logic [63:0] p;
    r = '0; h = '0; z = 1'b0; il = 1'b0; lat = 1;
    case (op)
      C_ADD:  r = x + y;
      C_SUB:  r = x - y;
      C_AND:  r = x & y;
      C_OR:   r = x | y;
      C_SLT:  r = (x < y) ? 32'd1 : 32'd0;
      C_EQ, C_NE: r = '0;
      C_MULU: begin
        p = {32'd0, x} * {32'd0, y};
        r = p[31:0]; h = p[63:32]; lat = W + 1;
      end
      C_DIVU: begin
`ifdef SEQ_ALU_DIV_EN
        if (y == 0) begin r = 32'hFFFF_FFFF; h = x; end
        else begin r = x / y; h = x % y; lat = W + 1; end
`else
        il = 1'b1;
`endif
      end
      default: il = 1'b1;
    endcase
    if (op == C_EQ) z = (x == y);
    else if (op == C_NE) z = (x != y);
    else if (!il) z = (r == 0);
  endfunction

  // Issue one op; returns latency (edges from start to done) and busy cycles
  task automatic run_op(input logic [3:0] op, input logic [W-1:0] x, input logic [W-1:0] y,
                        output int lat, output int busy_cnt);
    @(negedge clk);
    aluop = op; a = x; b = y; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 1; busy_cnt = 0;
    while (!done && lat < 100) begin
      if (busy) busy_cnt++;
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic apply(input string name, input logic [3:0] op, input logic [W-1:0] x,
                       input logic [W-1:0] y, input logic [W-1:0] er, input logic [W-1:0] eh,
                       input logic ez, input logic eil, input int elat);
    int lat, bc;
    run_op(op, x, y, lat, bc);
    check({name, ".latency"}, 64'(lat), 64'(elat));
    check({name, ".busy_cycles"}, 64'(bc), 64'(elat - 1));
    check({name, ".result"}, 64'(result), 64'(er));
    check({name, ".result_hi"}, 64'(result_hi), 64'(eh));
    check({name, ".zero"}, 64'(zero), 64'(ez));
    check({name, ".illegal"}, 64'(illegal_op), 64'(eil));
  endtask

  initial begin
    int lat, bc, dones;
    logic [3:0] rop;
    logic [W-1:0] ra, rb, er, eh;
    logic ez, eil;
    int elat;

    // Directed vectors (test plan values and boundaries)
    vecs.push_back('{C_ADD,  32'd5,          32'd7,          32'd12,         32'd0, 1'b0, 1'b0, 1});
    vecs.push_back('{C_SUB,  32'd3,          32'd5,          32'hFFFF_FFFE,  32'd0, 1'b0, 1'b0, 1});
    vecs.push_back('{C_EQ,   32'h1234,       32'h1234,       32'd0,          32'd0, 1'b1, 1'b0, 1});
    vecs.push_back('{C_NE,   32'h1234,       32'h1234,       32'd0,          32'd0, 1'b0, 1'b0, 1});
    vecs.push_back('{C_MULU, 32'hFFFF_FFFF,  32'd2,          32'hFFFF_FFFE,  32'd1, 1'b0, 1'b0, 33});
`ifdef SEQ_ALU_DIV_EN
    vecs.push_back('{C_DIVU, 32'd100,        32'd7,          32'd14,         32'd2, 1'b0, 1'b0, 33});
    vecs.push_back('{C_DIVU, 32'd9,          32'd0,          32'hFFFF_FFFF,  32'd9, 1'b0, 1'b0, 1});
`else
    vecs.push_back('{C_DIVU, 32'd100,        32'd7,          32'd0,          32'd0, 1'b0, 1'b1, 1});
    vecs.push_back('{C_DIVU, 32'd9,          32'd0,          32'd0,          32'd0, 1'b0, 1'b1, 1});
`endif
    vecs.push_back('{C_ADD,  32'hFFFF_FFFF,  32'd1,          32'd0,          32'd0, 1'b1, 1'b0, 1});
    vecs.push_back('{C_AND,  32'hF0F0_1234,  32'h0FF0_FFFF,  32'h00F0_1234,  32'd0, 1'b0, 1'b0, 1});
    vecs.push_back('{C_OR,   32'hF000_0000,  32'h0000_000F,  32'hF000_000F,  32'd0, 1'b0, 1'b0, 1});
    vecs.push_back('{C_SLT,  32'd1,          32'hFFFF_FFFF,  32'd1,          32'd0, 1'b0, 1'b0, 1});
    vecs.push_back('{C_SLT,  32'hFFFF_FFFF,  32'd1,          32'd0,          32'd0, 1'b1, 1'b0, 1});
    vecs.push_back('{4'b1111, 32'd3,         32'd4,          32'd0,          32'd0, 1'b0, 1'b1, 1});
    vecs.push_back('{C_MULU, 32'h8000_0000,  32'd2,          32'd0,          32'd1, 1'b1, 1'b0, 33});
    vecs.push_back('{C_EQ,   32'd1,          32'd2,          32'd0,          32'd0, 1'b0, 1'b0, 1});

    // Reset state
    #2 reset = 1'b1;
    #1;
    check("reset.busy", 64'(busy), 64'd0);
    check("reset.done", 64'(done), 64'd0);
    check("reset.result", 64'(result), 64'd0);
    check("reset.result_hi", 64'(result_hi), 64'd0);
    check("reset.zero", 64'(zero), 64'd0);
    check("reset.illegal", 64'(illegal_op), 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b0;

    // Table-driven vectors, issued back-to-back (start lands in the FIN cycle)
    for (int i = 0; i < vecs.size(); i++) begin
      apply($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
            vecs[i].res, vecs[i].hi, vecs[i].z, vecs[i].ill, vecs[i].lat);
    end

    // Outputs hold after done; done is a single pulse
    @(posedge clk); #1;
    check("hold.done", 64'(done), 64'd0);
    check("hold.result", 64'(result), 64'(vecs[vecs.size()-1].res));

    // MULU with an ADD start pulsed mid-operation: must be dropped
    @(negedge clk);
    aluop = C_MULU; a = 32'd3; b = 32'd5; start = 1'b1;
    @(posedge clk); #1;
    lat = 1;
    while (!done && lat < 100) begin
      @(negedge clk);
      if (lat == 5) begin aluop = C_ADD; a = 32'd100; b = 32'd100; start = 1'b1; end
      else start = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
    start = 1'b0;
    check("drop.latency", 64'(lat), 64'd33);
    check("drop.result", 64'(result), 64'd15);
    check("drop.result_hi", 64'(result_hi), 64'd0);
    @(posedge clk); #1;
    check("drop.no_extra_done", 64'(done), 64'd0);
    check("drop.hold", 64'(result), 64'd15);

    // Reset mid-iteration: immediate clear, no done afterwards
    @(negedge clk);
    aluop = C_MULU; a = 32'hFFFF; b = 32'hFFFF; start = 1'b1;
    @(posedge clk); #1;
    for (int c = 2; c <= 10; c++) begin
      @(negedge clk);
      if (c == 5) begin aluop = C_ADD; a = 32'd1; b = 32'd2; start = 1'b1; end
      else start = 1'b0;
      @(posedge clk); #1;
    end
    start = 1'b0;
    check("abort.busy_before", 64'(busy), 64'd1);
    #2 reset = 1'b1;
    #1;
    check("abort.busy", 64'(busy), 64'd0);
    check("abort.done", 64'(done), 64'd0);
    check("abort.result", 64'(result), 64'd0);
    check("abort.result_hi", 64'(result_hi), 64'd0);
    check("abort.zero", 64'(zero), 64'd0);
    check("abort.illegal", 64'(illegal_op), 64'd0);
    @(negedge clk) reset = 1'b0;
    dones = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done) dones++;
    end
    check("abort.no_done", 64'(dones), 64'd0);
    apply("post_reset_add", C_ADD, 32'd1, 32'd1, 32'd2, 32'd0, 1'b0, 1'b0, 1);

    // Randomized operations against the model
    for (int i = 0; i < 40; i++) begin
      rop = 4'($urandom_range(0, 15));
      ra = $urandom;
      case ($urandom_range(0, 5))
        0: rb = '0;
        1: rb = ra;
        2: rb = 32'($urandom_range(1, 300));
        default: rb = $urandom;
      endcase
      model(rop, ra, rb, er, eh, ez, eil, elat);
      apply($sformatf("rand%0d_op%0h", i, rop), rop, ra, rb, er, eh, ez, eil, elat);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
